io_event_capture: RTL
=====================

Name: io_event_capture

Overview:
Upstream feeder for the processor register file's hardware-written registers r20 (button), r22 (screen/frame) and r24 (collision).
- Converts an asynchronous push-button, a frame-rate tick and the collision detector's level output into 32-bit data words.
- Pairs each word with a one-cycle write strobe that drives the register file's button_signal_reg, screen_signal_reg and collision_signal_reg inputs.
- Contains a synchronizer, a debounce state machine, a frame divider and a collision edge detector.

Parameters:
DEBOUNCE_CYCLES, 250000, consecutive stable synchronized cycles required to accept a button change (5 ms at 50 MHz); legal range >= 2.
FRAME_DIV, 833333, clock cycles per frame tick (60 Hz at 50 MHz); legal range >= 2.

Ports:
clock  in  1  system clock, all state rising-edge.
ctrl_reset_n  in  1  asynchronous active-low reset.
button_raw  in  1  raw push-button, asynchronous, active-high.
collision_hit  in  1  collision level from the VGA collision detector, synchronous to clock.
game_run  in  1  high while the game is running; gates frame and collision events.
r20  out  32  button data word.
button_signal_reg  out  1  one-cycle write strobe for r20.
r22  out  32  frame count word.
screen_signal_reg  out  1  one-cycle write strobe for r22.
r24  out  32  collision data word.
collision_signal_reg  out  1  one-cycle write strobe for r24.

Behaviour:
- Reset (ctrl_reset_n low, async assert, sync release): all outputs 0; counters 0; FSM in IDLE; synchronizer flops 0.
- Button synchronizer: two-flop synchronizer on button_raw gives btn_s.
- Debounce FSM states:
  - IDLE: btn_s=1 -> PRESS_WAIT, count cleared.
  - PRESS_WAIT: btn_s=0 -> IDLE; count reaches DEBOUNCE_CYCLES-1 with btn_s=1 -> PRESSED.
  - PRESSED: btn_s=0 -> RELEASE_WAIT, count cleared.
  - RELEASE_WAIT: btn_s=1 -> PRESSED; count reaches DEBOUNCE_CYCLES-1 with btn_s=0 -> IDLE.
  - Any bounce restarts the wait from zero.
- Button strobes:
  - Entering PRESSED from PRESS_WAIT: register r20=32'd1 with button_signal_reg=1 for exactly one cycle.
  - Entering IDLE from RELEASE_WAIT: register r20=32'd0 with button_signal_reg=1 for exactly one cycle.
  - Other transitions (PRESS_WAIT->IDLE, RELEASE_WAIT->PRESSED) produce no strobe.
  - Latency from a clean button_raw edge to strobe: DEBOUNCE_CYCLES+3 cycles.
  - r20 holds its value between strobes.
  - Button events are independent of game_run, so the button can start the game.
- Frame divider:
  - Counter runs 0..FRAME_DIV-1 and wraps.
  - On wrap: frame_count increments (32-bit, wraps FFFFFFFF->0); the next cycle drives r22=new count with screen_signal_reg=1 for one cycle.
  - game_run=0: divider and frame_count hold; no strobe.
- Collision:
  - Registered edge detect on collision_hit.
  - A 0->1 transition with game_run=1 gives, the next cycle, r24=32'd1 with collision_signal_reg=1 for one cycle.
  - The history flop updates regardless of game_run, so a level already high when game_run rises produces no event.
  - Held-high collision_hit produces one event only.
- Simultaneous events: strobes are independent and may assert in the same cycle; no arbitration.
- Register file interaction: if software writes the same register in the strobe cycle, the hardware word wins.
- Reset mid-debounce or mid-frame discards partial progress; no strobe is issued by reset.

Optional Feature:
COLLISION_COUNT_EN
- Defined: r24 carries a saturating 32-bit count of accepted collision events since reset; it stops at FFFFFFFF and still strobes.
- Undefined: r24 is always 32'd1 on a collision event.

Decomposition:
- Shared package io_event_pkg: debounce FSM state enum (IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT) and localparams BTN_PRESS_WORD=32'd1, BTN_RELEASE_WORD=32'd0, COLLISION_WORD=32'd1.
- One sub-module: button_debouncer (synchronizer plus FSM), outputting a press/release pulse and level.
- Frame divider and collision edge logic stay inline.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, FRAME_DIV=8.
1. Reset: hold ctrl_reset_n=0 with button_raw=1 and collision_hit=1 -> all outputs 0, no strobes; after release, first press strobe appears exactly 7 cycles later.
2. Clean press: button_raw 0->1, held 20 cycles -> r20=1 with one button_signal_reg pulse at +7 cycles; release gives r20=0 pulse at +7.
3. Bounce: button_raw toggles every 2 cycles for 12 cycles, then stays 1 -> exactly one press strobe, 7 cycles after the final edge.
4. Frames: game_run=1 for 40 cycles -> 5 screen strobes with r22=1..5; drop game_run for 10 cycles -> no strobes and r22 holds 5; restore game_run -> the next strobe has r22=6.
5. Collision: collision_hit high for 10 cycles with game_run=1 -> one strobe, r24=1; pulse again with game_run=0 -> no strobe; with COLLISION_COUNT_EN defined, three accepted hits give r24=1,2,3.
6. Simultaneous: align a press commit, a frame wrap and a collision edge in the same cycle -> all three strobes high in the same cycle with correct words.

Source files
------------

// File: rtl/io_event_pkg.sv
// Shared types and constant data words for the io_event_capture block.
package io_event_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } deb_state_t;

    localparam logic [31:0] BTN_PRESS_WORD   = 32'd1;
    localparam logic [31:0] BTN_RELEASE_WORD = 32'd0;
    localparam logic [31:0] COLLISION_WORD   = 32'd1;

    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer plus debounce FSM; emits a one-cycle commit pulse
// and the newly accepted debounced level in the same cycle.
module button_debouncer
    import io_event_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clock,
    input  logic ctrl_reset_n,
    input  logic button_raw,
    output logic event_pulse,
    output logic event_level
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] COUNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    deb_state_t    r_state;
    deb_state_t    w_state_next;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_next;
    logic          w_btn_s;

    assign w_btn_s = r_sync2;

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_state <= IDLE;
            r_count <= '0;
        end else begin
            r_sync1 <= button_raw;
            r_sync2 <= r_sync1;
            r_state <= w_state_next;
            r_count <= w_count_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_count_next = '0;
        event_pulse  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_btn_s) w_state_next = PRESS_WAIT;
            end
            PRESS_WAIT: begin
                if (!w_btn_s) begin
                    w_state_next = IDLE;
                end else if (r_count == COUNT_LAST) begin
                    w_state_next = PRESSED;
                    event_pulse  = 1'b1;
                end else begin
                    w_count_next = r_count + CW'(1);
                end
            end
            PRESSED: begin
                if (!w_btn_s) w_state_next = RELEASE_WAIT;
            end
            RELEASE_WAIT: begin
                if (w_btn_s) begin
                    w_state_next = PRESSED;
                end else if (r_count == COUNT_LAST) begin
                    w_state_next = IDLE;
                    event_pulse  = 1'b1;
                end else begin
                    w_count_next = r_count + CW'(1);
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Level as it will be after this edge, so the pulse and level agree.
    assign event_level = (w_state_next == PRESSED) || (w_state_next == RELEASE_WAIT);

endmodule

// File: rtl/io_event_capture.sv
// Button, frame and collision event words with one-cycle write strobes.
// Optional build macro COLLISION_COUNT_EN: r24 carries a saturating hit count.
module io_event_capture
    import io_event_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int FRAME_DIV       = 833333
) (
    input  logic        clock,
    input  logic        ctrl_reset_n,
    input  logic        button_raw,
    input  logic        collision_hit,
    input  logic        game_run,
    output logic [31:0] r20,
    output logic        button_signal_reg,
    output logic [31:0] r22,
    output logic        screen_signal_reg,
    output logic [31:0] r24,
    output logic        collision_signal_reg
);

    localparam int FW = (FRAME_DIV > 2) ? $clog2(FRAME_DIV) : 1;
    localparam logic [FW-1:0] DIV_LAST = FW'(FRAME_DIV - 1);

    logic          w_btn_event;
    logic          w_btn_level;
    logic [FW-1:0] r_div;
    logic [31:0]   r_frame_count;
    logic          r_frame_wrap;
    logic          w_div_wrap;
    logic          r_coll_hist;
    logic          w_coll_event;
`ifdef COLLISION_COUNT_EN
    logic [31:0]   r_coll_count;
    logic [31:0]   w_coll_next;
    assign w_coll_next = sat_inc32(r_coll_count);
`endif

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clock       (clock),
        .ctrl_reset_n(ctrl_reset_n),
        .button_raw  (button_raw),
        .event_pulse (w_btn_event),
        .event_level (w_btn_level)
    );

    assign w_div_wrap   = game_run && (r_div == DIV_LAST);
    // History follows the input even while the game is stopped.
    assign w_coll_event = collision_hit && !r_coll_hist && game_run;

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            r20                  <= '0;
            button_signal_reg    <= 1'b0;
            r22                  <= '0;
            screen_signal_reg    <= 1'b0;
            r24                  <= '0;
            collision_signal_reg <= 1'b0;
            r_div                <= '0;
            r_frame_count        <= '0;
            r_frame_wrap         <= 1'b0;
            r_coll_hist          <= 1'b0;
`ifdef COLLISION_COUNT_EN
            r_coll_count         <= '0;
`endif
        end else begin
            button_signal_reg <= w_btn_event;
            if (w_btn_event) r20 <= w_btn_level ? BTN_PRESS_WORD : BTN_RELEASE_WORD;

            if (game_run) begin
                if (w_div_wrap) begin
                    r_div         <= '0;
                    r_frame_count <= r_frame_count + 32'd1;
                end else begin
                    r_div <= r_div + FW'(1);
                end
            end
            r_frame_wrap      <= w_div_wrap;
            screen_signal_reg <= r_frame_wrap;
            if (r_frame_wrap) r22 <= r_frame_count;

            r_coll_hist          <= collision_hit;
            collision_signal_reg <= w_coll_event;
            if (w_coll_event) begin
`ifdef COLLISION_COUNT_EN
                r_coll_count <= w_coll_next;
                r24          <= w_coll_next;
`else
                r24          <= COLLISION_WORD;
`endif
            end
        end
    end

endmodule
